db_prbsgchk: RTL and testbench

DB_PRBSGCHK -- requirements
Module: db_prbsgchk

---
 rtl/db_prbs_pkg.sv | 14 +
 rtl/db_prbsstep.sv | 29 ++
 rtl/db_prbsgchk.sv | 164 ++++++++++++++++
 tb/tb_db_prbsgchk.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/db_prbs_pkg.sv
// Shared definitions for the PRBS generator/checker: checker FSM encoding and
// error-counter width / saturation value.
package db_prbs_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } chk_st_e;

  localparam int              CNTW   = 16;
  localparam logic [CNTW-1:0] CNTSAT = 16'hFFFF;

endpackage

// File: rtl/db_prbsstep.sv
// Combinational DW-step advance of a two-tap Fibonacci LFSR.
// bits[DW-1] is the first bit emitted; s_nxt is the state after DW steps.
module db_prbsstep #(
  parameter int LEN     = 15,
  parameter int HIGHEXP = 14,
  parameter int LOWEXP  = 13,
  parameter int DW      = 8
) (
  input  logic [LEN-1:0] s,
  output logic [LEN-1:0] s_nxt,
  output logic [DW-1:0]  bits
);

  logic [LEN-1:0] t;
  logic           fb;

  always_comb begin
    t    = s;
    fb   = 1'b0;
    bits = '0;
    for (int i = DW-1; i >= 0; i--) begin
      fb      = t[HIGHEXP] ^ t[LOWEXP];
      bits[i] = fb;
      t       = {t[LEN-2:0], fb};
    end
    s_nxt = t;
  end

endmodule

// File: rtl/db_prbsgchk.sv
// PRBS word generator plus self-synchronising checker (HUNT/VERIFY/LOCK).
// Define DB_PRBSGCHK_ERRINJ_EN to add port iinj, which flips bit 0 of one generated word.
module db_prbsgchk
  import db_prbs_pkg::*;
#(
  parameter int LEN     = 15,
  parameter int HIGHEXP = 14,
  parameter int LOWEXP  = 13,
  parameter int DW      = 8,
  parameter int SYNCCNT = 8,
  parameter int LOSSCNT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            igen_en,
`ifdef DB_PRBSGCHK_ERRINJ_EN
  input  logic            iinj,
`endif
  output logic [DW-1:0]   ogen_dat,
  output logic            ogen_vld,
  input  logic            ichk_vld,
  input  logic [DW-1:0]   ichk_dat,
  input  logic            iclr,
  output logic            olock,
  output logic            oerr,
  output logic [CNTW-1:0] oerrcnt
);

  localparam int BCW = $clog2(LEN + DW + 1);
  localparam int GCW = $clog2(SYNCCNT + 1);
  localparam int LCW = $clog2(LOSSCNT + 1);

  // ---------------- generator ----------------
  logic [LEN-1:0] gs, gs_nxt;
  logic [DW-1:0]  gbits;

  db_prbsstep #(.LEN(LEN), .HIGHEXP(HIGHEXP), .LOWEXP(LOWEXP), .DW(DW)) u_gstep (
    .s(gs), .s_nxt(gs_nxt), .bits(gbits)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gs       <= '1;
      ogen_dat <= '0;
      ogen_vld <= 1'b0;
    end else begin
      ogen_vld <= igen_en;
      if (igen_en) begin
        gs <= gs_nxt;
`ifdef DB_PRBSGCHK_ERRINJ_EN
        // Injection corrupts only the output word; the sequence state is untouched.
        ogen_dat <= gbits ^ DW'(iinj);
`else
        ogen_dat <= gbits;
`endif
      end
    end
  end

  // ---------------- checker ----------------
  chk_st_e        st, st_nxt;
  logic [LEN-1:0] cs, cs_nxt, cs_pred, cs_rx;
  logic [DW-1:0]  cbits;
  logic [BCW-1:0] bcnt, bcnt_nxt;
  logic [GCW-1:0] gcnt, gcnt_nxt;
  logic [LCW-1:0] lcnt, lcnt_nxt;
  logic           err_nxt;
  logic [CNTW-1:0] ecnt_nxt;

  db_prbsstep #(.LEN(LEN), .HIGHEXP(HIGHEXP), .LOWEXP(LOWEXP), .DW(DW)) u_cstep (
    .s(cs), .s_nxt(cs_pred), .bits(cbits)
  );

  // Received word shifted in MSB-first.
  always_comb begin
    cs_rx = cs;
    for (int i = DW-1; i >= 0; i--) cs_rx = {cs_rx[LEN-2:0], ichk_dat[i]};
  end

  always_comb begin
    st_nxt   = st;
    cs_nxt   = cs;
    bcnt_nxt = bcnt;
    gcnt_nxt = gcnt;
    lcnt_nxt = lcnt;
    err_nxt  = 1'b0;
    ecnt_nxt = oerrcnt;
    if (ichk_vld) begin
      unique case (st)
        HUNT: begin
          cs_nxt   = cs_rx;
          bcnt_nxt = (bcnt >= BCW'(LEN)) ? bcnt : bcnt + BCW'(DW);
          if (bcnt_nxt >= BCW'(LEN) && cs_rx != '0) begin
            st_nxt   = VERIFY;
            gcnt_nxt = '0;
          end
        end
        VERIFY: begin
          cs_nxt = cs_rx;
          if (ichk_dat == cbits) begin
            if (gcnt == GCW'(SYNCCNT-1)) begin
              st_nxt   = LOCK;
              gcnt_nxt = '0;
              lcnt_nxt = '0;
            end else begin
              gcnt_nxt = gcnt + GCW'(1);
            end
          end else begin
            st_nxt   = HUNT;
            bcnt_nxt = '0;
            gcnt_nxt = '0;
          end
        end
        LOCK: begin
          // Flywheel on the prediction so line errors never enter the register.
          cs_nxt = cs_pred;
          if (ichk_dat != cbits) begin
            err_nxt  = 1'b1;
            ecnt_nxt = (oerrcnt == CNTSAT) ? oerrcnt : oerrcnt + CNTW'(1);
            if (lcnt == LCW'(LOSSCNT-1)) begin
              st_nxt   = HUNT;
              bcnt_nxt = '0;
              lcnt_nxt = '0;
            end else begin
              lcnt_nxt = lcnt + LCW'(1);
            end
          end else begin
            lcnt_nxt = '0;
          end
        end
        default: begin
          st_nxt   = HUNT;
          bcnt_nxt = '0;
          gcnt_nxt = '0;
          lcnt_nxt = '0;
        end
      endcase
    end
    if (iclr) ecnt_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= HUNT;
      cs      <= '0;
      bcnt    <= '0;
      gcnt    <= '0;
      lcnt    <= '0;
      olock   <= 1'b0;
      oerr    <= 1'b0;
      oerrcnt <= '0;
    end else begin
      st      <= st_nxt;
      cs      <= cs_nxt;
      bcnt    <= bcnt_nxt;
      gcnt    <= gcnt_nxt;
      lcnt    <= lcnt_nxt;
      olock   <= (st_nxt == LOCK);
      oerr    <= err_nxt;
      oerrcnt <= ecnt_nxt;
    end
  end

endmodule

// File: tb/tb_db_prbsgchk.sv
// Self-checking bench for db_prbsgchk: table-driven generator vectors, hand sequences
// for lock/loss/saturation, and randomized traffic against a bit-stream reference model.
`timescale 1ns/1ps
module tb_db_prbsgchk;
  import db_prbs_pkg::*;

  localparam int LEN = 15, HX = 14, LX = 13, DW = 8, SYNC = 8, LOSS = 4;
  localparam int PER = (1 << LEN) - 1;

  logic            clk, rst, igen_en, ichk_vld, iclr, iinj;
  logic [DW-1:0]   ichk_dat, ogen_dat;
  logic            ogen_vld, olock, oerr;
  logic [CNTW-1:0] oerrcnt;
  logic            s_vld, s_clr, s_gvld, s_lock, s_err;
  logic [DW-1:0]   s_dat, s_gdat;
  logic [CNTW-1:0] s_cnt;

  db_prbsgchk dut (
    .clk(clk), .rst(rst), .igen_en(igen_en),
`ifdef DB_PRBSGCHK_ERRINJ_EN
    .iinj(iinj),
`endif
    .ogen_dat(ogen_dat), .ogen_vld(ogen_vld), .ichk_vld(ichk_vld), .ichk_dat(ichk_dat),
    .iclr(iclr), .olock(olock), .oerr(oerr), .oerrcnt(oerrcnt)
  );

  // Second instance that never drops lock, so the counter can be driven to saturation quickly.
  db_prbsgchk #(.LOSSCNT(1 << 17)) u_sat (
    .clk(clk), .rst(rst), .igen_en(1'b0),
`ifdef DB_PRBSGCHK_ERRINJ_EN
    .iinj(1'b0),
`endif
    .ogen_dat(s_gdat), .ogen_vld(s_gvld), .ichk_vld(s_vld), .ichk_dat(s_dat),
    .iclr(s_clr), .olock(s_lock), .oerr(s_err), .oerrcnt(s_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference: PRBS bit stream ----------------
  // prbs[0..LEN-1] is the all-ones seed history; emitted bit k is prbs[LEN + k mod PER].
  bit prbs [LEN+PER];

  function automatic logic [DW-1:0] word(input longint k);
    logic [DW-1:0] w;
    for (int i = 0; i < DW; i++) w[DW-1-i] = prbs[LEN + int'((k + i) % PER)];
    return w;
  endfunction

  // ---------------- reference: checker ----------------
  bit hq[$];            // last LEN bits held by the checker, oldest first
  int mmode, mloaded, mgood, mloss;   // mode 0=hunt 1=verify 2=lock
  logic [15:0] mcnt;
  bit merr, mlock;
  longint gk, sk;
  logic [DW-1:0] gexp;

  task automatic push_rx(input logic [DW-1:0] w);
    for (int i = DW-1; i >= 0; i--) begin
      hq.push_back(w[i]);
      void'(hq.pop_front());
    end
  endtask

  task automatic model_word(input logic [DW-1:0] w);
    logic [DW-1:0] pr;
    bit t[$];
    bit b, nz;
    t = hq;
    pr = '0;
    for (int i = DW-1; i >= 0; i--) begin
      b = t[LEN-1-HX] ^ t[LEN-1-LX];
      pr[i] = b;
      t.push_back(b);
      void'(t.pop_front());
    end
    case (mmode)
      0: begin
        push_rx(w);
        mloaded += DW;
        nz = 0;
        foreach (hq[j]) nz |= hq[j];
        if (mloaded >= LEN && nz) begin mmode = 1; mgood = 0; end
      end
      1: begin
        push_rx(w);
        if (w == pr) begin
          mgood++;
          if (mgood == SYNC) begin mmode = 2; mloss = 0; end
        end else begin
          mmode = 0; mloaded = 0; mgood = 0;
        end
      end
      default: begin
        hq = t;
        if (w != pr) begin
          merr = 1;
          if (mcnt != 16'hFFFF) mcnt++;
          mloss++;
          if (mloss == LOSS) begin mmode = 0; mloaded = 0; mloss = 0; end
        end else mloss = 0;
      end
    endcase
  endtask

  task automatic model_reset();
    hq.delete();
    for (int i = 0; i < LEN; i++) hq.push_back(1'b0);
    mmode = 0; mloaded = 0; mgood = 0; mloss = 0;
    mcnt = '0; merr = 0; mlock = 0;
    gk = 0; sk = 0; gexp = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; igen_en = 0; ichk_vld = 0; ichk_dat = '0; iclr = 0; iinj = 0;
    s_vld = 0; s_dat = '0; s_clr = 0;
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic next_src(output logic [DW-1:0] w);
    w = word(sk);
    sk += DW;
  endtask

  // One cycle on the main instance, compared against the model.
  task automatic tick(input logic gen, input logic vld, input logic [DW-1:0] w, input logic clr);
    igen_en = gen; ichk_vld = vld; ichk_dat = w; iclr = clr;
    if (gen) begin gexp = word(gk); gk += DW; end
    merr = 0;
    if (vld) model_word(w);
    if (clr) mcnt = '0;
    mlock = (mmode == 2);
    @(posedge clk); @(negedge clk);
    chk("ogen_vld", ogen_vld, gen);
    chk("ogen_dat", ogen_dat, gexp);
    chk("olock", olock, mlock);
    chk("oerr", oerr, merr);
    chk("oerrcnt", oerrcnt, mcnt);
  endtask

  task automatic sat_cyc(input logic [DW-1:0] w, input logic clr);
    s_vld = 1; s_dat = w; s_clr = clr;
    @(posedge clk); @(negedge clk);
  endtask

  typedef struct {
    logic          en;
    logic          vld;
    logic [DW-1:0] dat;
  } gvec_t;

  gvec_t gtab [8];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not finish within time limit");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w;
    int lk, pulses, burst;
    longint gkt;

    for (int n = 0; n < LEN; n++) prbs[n] = 1'b1;
    for (int n = LEN; n < LEN + PER; n++) prbs[n] = prbs[n-HX-1] ^ prbs[n-LX-1];

    rst = 1; igen_en = 0; ichk_vld = 0; ichk_dat = '0; iclr = 0; iinj = 0;
    s_vld = 0; s_dat = '0; s_clr = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_ogen_vld", ogen_vld, 0);
    chk("rst_ogen_dat", ogen_dat, 0);
    chk("rst_olock", olock, 0);
    chk("rst_oerr", oerr, 0);
    chk("rst_oerrcnt", oerrcnt, 0);
    rst = 0;

    // ---- generator vectors: first two words are fixed, holds when idle ----
    gtab[0] = '{1'b1, 1'b1, 8'h00};
    gtab[1] = '{1'b1, 1'b1, 8'h02};
    gtab[2] = '{1'b0, 1'b0, 8'h02};
    gtab[3] = '{1'b0, 1'b0, 8'h02};
    gkt = 16;
    for (int i = 4; i < 8; i++) begin
      gtab[i].en  = (i != 6);
      gtab[i].vld = gtab[i].en;
      if (gtab[i].en) begin gtab[i].dat = word(gkt); gkt += DW; end
      else gtab[i].dat = gtab[i-1].dat;
    end
    for (int i = 0; i < 8; i++) begin
      igen_en = gtab[i].en;
      @(posedge clk); @(negedge clk);
      chk($sformatf("gtab%0d_vld", i), ogen_vld, gtab[i].vld);
      chk($sformatf("gtab%0d_dat", i), ogen_dat, gtab[i].dat);
    end

    // ---- acquisition, single error, loss of lock, relock, clear-vs-increment ----
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      next_src(w); tick(0, 1, w, 0);
      chk($sformatf("acq_lock%0d", i), olock, (i == 10));
    end
    chk("acq_errcnt", oerrcnt, 0);
    next_src(w); tick(0, 1, w ^ 8'h10, 0);
    chk("err1_oerr", oerr, 1);
    chk("err1_cnt", oerrcnt, 1);
    chk("err1_lock", olock, 1);
    next_src(w); tick(0, 1, w, 0);
    chk("err1_pulse_end", oerr, 0);
    for (int i = 1; i <= 4; i++) begin
      next_src(w); tick(0, 1, ~w, 0);
      chk($sformatf("loss_lock%0d", i), olock, (i < 4));
    end
    chk("loss_cnt", oerrcnt, 5);
    for (int i = 1; i <= 10; i++) begin next_src(w); tick(0, 1, w, 0); end
    chk("relock", olock, 1);
    next_src(w); tick(0, 1, w ^ 8'h01, 1);
    chk("clr_win_cnt", oerrcnt, 0);
    chk("clr_win_oerr", oerr, 1);
    next_src(w); tick(1, 1, ~w, 0);
    chk("post_clr_cnt", oerrcnt, 1);
    // asynchronous reset while locked
    @(negedge clk);
    rst = 1;
    #1;
    chk("arst_lock", olock, 0);
    chk("arst_cnt", oerrcnt, 0);
    chk("arst_gvld", ogen_vld, 0);
    @(negedge clk);
    rst = 0;
    model_reset();

    // ---- all-zero input never locks ----
    for (int i = 0; i < 30; i++) begin
      tick(0, 1, '0, 0);
      chk("zero_nolock", olock, 0);
    end

    // ---- randomized traffic against the model ----
    do_reset();
    burst = 0;
    for (int c = 0; c < 2500; c++) begin
      logic gen, vld, clr;
      gen = ($urandom % 2) == 1;
      vld = ($urandom % 4) != 0;
      clr = ($urandom % 50) == 0;
      w = '0;
      if (vld) begin
        if (burst == 0 && ($urandom % 40) == 0) burst = $urandom_range(1, 6);
        if (($urandom % 100) < 2) w = DW'($urandom);            // inserted word, stream not advanced
        else begin
          next_src(w);
          if (burst > 0) begin w ^= DW'($urandom_range(1, (1 << DW) - 1)); burst--; end
          else if (($urandom % 100) < 3) w ^= DW'($urandom_range(1, (1 << DW) - 1));
        end
      end
      tick(gen, vld, w, clr);
    end

    // ---- generator looped back into checker ----
    do_reset();
    lk = -1;
    for (int c = 0; c < 40 && lk < 0; c++) begin
      igen_en = 1; ichk_vld = ogen_vld; ichk_dat = ogen_dat;
      @(posedge clk); @(negedge clk);
      if (olock) lk = c;
    end
    chk("loop_lock_cyc", lk, 10);
    chk("loop_errcnt", oerrcnt, 0);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      igen_en = 1; ichk_vld = ogen_vld; ichk_dat = ogen_dat;
      iinj = (c == 1);
      @(posedge clk); @(negedge clk);
      if (oerr) pulses++;
    end
    iinj = 0;
`ifdef DB_PRBSGCHK_ERRINJ_EN
    chk("inj_pulses", pulses, 1);
    chk("inj_cnt", oerrcnt, 1);
`else
    chk("inj_pulses", pulses, 0);
    chk("inj_cnt", oerrcnt, 0);
`endif
    chk("inj_lock", olock, 1);

    // ---- counter saturation ----
    do_reset();
    gkt = 0;
    for (int i = 0; i < 10; i++) begin sat_cyc(word(gkt), 0); gkt += DW; end
    chk("sat_lock", s_lock, 1);
    for (int i = 0; i < 65534; i++) begin sat_cyc(word(gkt) ^ 8'h01, 0); gkt += DW; end
    chk("sat_fffe", s_cnt, 16'hFFFE);
    sat_cyc(word(gkt) ^ 8'h01, 0); gkt += DW;
    chk("sat_ffff", s_cnt, 16'hFFFF);
    sat_cyc(word(gkt) ^ 8'h80, 0); gkt += DW;
    chk("sat_hold", s_cnt, 16'hFFFF);
    chk("sat_hold_err", s_err, 1);
    sat_cyc(word(gkt) ^ 8'h01, 1); gkt += DW;
    chk("sat_clr", s_cnt, 0);
    sat_cyc(word(gkt) ^ 8'h01, 0); gkt += DW;
    chk("sat_after_clr", s_cnt, 1);
    chk("sat_lock_held", s_lock, 1);
    s_vld = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
